// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates one single-ported RAM between an instruction cache and a data
// cache. The dcache normally wins ties. A starvation counter guarantees the
// icache a grant after STARVE_LIMIT consecutive dcache grants taken while the
// icache was waiting.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   iREN, iaddr          icache read request / word address
//   iwait, iload         icache stall / read data
//   dREN, dWEN           dcache read / write request
//   daddr, dstore        dcache word address / write data
//   dwait, dload         dcache stall / read data
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (0 FREE 1 BUSY 2 ACCESS 3 ERROR)
//   owner                current grant (0 none, 1 dcache, 2 icache)
//
// state  | meaning
// IDLE   | no grant; RAM strobes low; choose next owner
// DGRANT | dcache owns the RAM until ACCESS or request drop
// IGRANT | icache owns the RAM until ACCESS or request drop
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
   parameter logic [3:0] STARVE_LIMIT = 4'd8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;

   logic d_req;
   logic d_done;
   logic i_done;
   logic starved;

   assign d_req   = dREN | dWEN;
   assign d_done  = (state_q == DGRANT) && d_req && (ramstate == RAM_ACCESS);
   assign i_done  = (state_q == IGRANT) && iREN  && (ramstate == RAM_ACCESS);
   assign starved = iREN && (starve_cnt_q == STARVE_LIMIT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_req && !starved) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end
         // A dropped request ends the grant without waiting for the RAM.
         DGRANT: if (!d_req || d_done) state_d = IDLE;
         IGRANT: if (!iREN  || i_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!iREN || i_done) begin
         starve_cnt_d = 4'd0;
      end else if ((state_q == IDLE) && (state_d == DGRANT) &&
                   (starve_cnt_q < STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // RAM side is steered combinationally from the registered grant so that a
   // dropped request pulls its strobe low in the same cycle.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      case (state_q)
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
         end
         IGRANT: begin
            ramaddr  = iaddr;
            ramREN   = iREN;
         end
         default: ;
      endcase
   end

   assign owner = state_q;
   assign iwait = iREN  & ~i_done;
   assign dwait = d_req & ~d_done;
   assign iload = ramload;
   assign dload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

   localparam int LIMIT = 8;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [1:0]  owner;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state: who holds the RAM and how long icache has waited
   int m_owner = 0;
   int m_starve = 0;
   bit m_i_done, m_d_done;

   // values sampled in the latest cycle, for directed scenario bookkeeping
   logic [1:0]  obs_owner;
   logic        obs_iwait, obs_dwait, obs_ramREN, obs_ramWEN;
   logic [31:0] obs_ramaddr, obs_ramstore;

   cache_mem_arbiter #(.STARVE_LIMIT(4'd8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .owner(owner)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already applied (just after a rising edge).
   // Check every output against the model, then advance the model with the
   // same inputs the DUT sees at the next rising edge.
   task automatic cycle();
      bit dreq;
      int nxt;
      logic        e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      #3;
      dreq = dREN || dWEN;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      if (m_owner == 1) begin
         e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
      end else if (m_owner == 2) begin
         e_addr = iaddr; e_ren = iREN;
      end
      m_d_done = (m_owner == 1) && dreq && (ramstate == 2'd2);
      m_i_done = (m_owner == 2) && iREN && (ramstate == 2'd2);

      obs_owner = owner; obs_iwait = iwait; obs_dwait = dwait;
      obs_ramREN = ramREN; obs_ramWEN = ramWEN;
      obs_ramaddr = ramaddr; obs_ramstore = ramstore;

      chk("owner",    {30'd0, owner}, m_owner);
      chk("ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
      chk("ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
      chk("ramaddr",  ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("iwait",    {31'd0, iwait}, {31'd0, iREN && !m_i_done});
      chk("dwait",    {31'd0, dwait}, {31'd0, dreq && !m_d_done});
      chk("iload",    iload, ramload);
      chk("dload",    dload, ramload);

      if (RST) begin
         m_owner = 0; m_starve = 0;
      end else begin
         nxt = m_owner;
         if (m_owner == 0) begin
            if (dreq && !(iREN && m_starve == LIMIT)) nxt = 1;
            else if (iREN) nxt = 2;
         end else if (m_owner == 1) begin
            if (!dreq || ramstate == 2'd2) nxt = 0;
         end else begin
            if (!iREN || ramstate == 2'd2) nxt = 0;
         end
         if (!iREN || m_i_done) m_starve = 0;
         else if (m_owner == 0 && nxt == 1 && m_starve < LIMIT) m_starve++;
         m_owner = nxt;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic quiet();
      RST = 0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramstate = 0;
      ramload = $urandom;
   endtask

   initial begin
      int n_dc, n_iz, guard;
      bit seen_i;
      quiet();
      RST = 1;
      @(posedge CLK);
      #1;
      cycle();
      // reset state, RST now low
      quiet();
      chk("rst_owner", {30'd0, owner}, 32'd0);
      chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);

      // icache alone, ACCESS on the third IGRANT cycle
      iREN = 1; iaddr = 32'h40;
      cycle();
      n_iz = 0;
      for (int k = 0; k < 3; k++) begin
         ramstate = (k == 2) ? 2'd2 : 2'd1;
         ramload = $urandom;
         cycle();
         chk("i_alone_owner", {30'd0, obs_owner}, 32'd2);
         chk("i_alone_ren", {31'd0, obs_ramREN}, 32'd1);
         chk("i_alone_addr", obs_ramaddr, 32'h40);
         if (!obs_iwait) n_iz++;
      end
      chk("i_alone_iwait0_count", n_iz, 32'd1);
      quiet();
      cycle();
      chk("i_alone_back_idle", {30'd0, obs_owner}, 32'd0);

      // simultaneous write and icache: dcache first, icache after
      iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; iaddr = 32'h44;
      cycle();
      ramstate = 2'd2;
      cycle();
      chk("tie_owner", {30'd0, obs_owner}, 32'd1);
      chk("tie_wen", {31'd0, obs_ramWEN}, 32'd1);
      chk("tie_store", obs_ramstore, 32'hDEADBEEF);
      chk("tie_iwait", {31'd0, obs_iwait}, 32'd1);
      dWEN = 0; ramstate = 2'd0;
      cycle();
      chk("tie_iwait_idle", {31'd0, obs_iwait}, 32'd1);
      ramstate = 2'd2;
      cycle();
      chk("tie_then_i", {30'd0, obs_owner}, 32'd2);
      quiet();
      cycle();

      // both dcache strobes: write wins; then drop request while BUSY
      dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h1234;
      cycle();
      ramstate = 2'd1;
      cycle();
      chk("both_wen", {31'd0, obs_ramWEN}, 32'd1);
      chk("both_ren", {31'd0, obs_ramREN}, 32'd0);
      dREN = 0; dWEN = 0;
      cycle();
      chk("drop_ren", {31'd0, obs_ramREN}, 32'd0);
      chk("drop_wen", {31'd0, obs_ramWEN}, 32'd0);
      cycle();
      chk("drop_idle", {30'd0, obs_owner}, 32'd0);

      // starvation: dREN and iREN held, RAM always completes
      quiet();
      dREN = 1; iREN = 1; ramstate = 2'd2; daddr = 32'h300; iaddr = 32'h80;
      n_dc = 0; seen_i = 0; guard = 0;
      while (!seen_i && guard < 60) begin
         cycle();
         if (obs_owner == 2'd2) seen_i = 1;
         else if (obs_owner == 2'd1 && !obs_dwait) n_dc++;
         guard++;
      end
      chk("starve_seen_igrant", {31'd0, seen_i}, 32'd1);
      chk("starve_dcomp", n_dc, LIMIT);
      // counter cleared by the icache completion: dcache wins the next tie
      cycle();
      cycle();
      chk("starve_cleared", {30'd0, obs_owner}, 32'd1);
      quiet();
      cycle();
      cycle();

      // reset during IGRANT with RAM busy
      iREN = 1; iaddr = 32'h500;
      cycle();
      ramstate = 2'd1; RST = 1;
      cycle();
      chk("rst_mid_prev_owner", {30'd0, obs_owner}, 32'd2);
      RST = 0;
      cycle();
      chk("rst_mid_owner", {30'd0, obs_owner}, 32'd0);
      chk("rst_mid_ren", {31'd0, obs_ramREN}, 32'd0);
      chk("rst_mid_addr", obs_ramaddr, 32'd0);
      quiet();
      cycle();

      // randomized traffic; requesters mostly hold until served
      for (int n = 0; n < 3000; n++) begin
         RST = ($urandom_range(0, 99) == 0);
         if (!(iREN && !m_i_done) || $urandom_range(0, 15) == 0)
            iREN = $urandom_range(0, 1);
         if (!((dREN || dWEN) && !m_d_done) || $urandom_range(0, 15) == 0) begin
            dREN = $urandom_range(0, 1);
            dWEN = ($urandom_range(0, 2) == 0);
         end
         iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         ramload = $urandom;
         ramstate = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4'd8: number of consecutive dcache grants while iREN is pending before icache is forced a grant.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 iwait  out  1  icache stall; low only in the cycle its access completes.
REQ-007 iload  out  32  icache read data.
REQ-008 dREN  in  1  dcache read request.
REQ-009 dWEN  in  1  dcache write request.
REQ-010 daddr  in  32  dcache word address.
REQ-011 dstore  in  32  dcache write data.
REQ-012 dwait  out  1  dcache stall; low only in the cycle its access completes.
REQ-013 dload  out  32  dcache read data.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-020 owner  out  2  current grant: 0 none, 1 dcache, 2 icache.

Function
REQ-021 FSM states SHALL be IDLE, DGRANT, IGRANT; owner SHALL equal 0/1/2 respectively.
REQ-022 IDLE: if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT) -> DGRANT; else if iREN -> IGRANT; else stay.
REQ-023 Grant latency SHALL be one cycle: no RAM strobe asserted in IDLE.
REQ-024 DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both).
REQ-025 IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-026 In IDLE all ram* outputs SHALL be 0.
REQ-027 Access completes in the cycle ramstate==ACCESS while granted; owner's wait SHALL be 0 that cycle; FSM SHALL return to IDLE next cycle.
REQ-028 ramstate FREE, BUSY or ERROR while granted: stay in grant, owner's wait=1.
REQ-029 If owner drops its request (DGRANT: dREN|dWEN==0; IGRANT: iREN==0) before completion -> IDLE next cycle, strobes deasserted combinationally that cycle.
REQ-030 iwait=1 whenever iREN=1 and not completing; iwait=0 when iREN=0; dwait likewise for dREN|dWEN.
REQ-031 iload=dload=ramload at all times (consumers qualify with wait).
REQ-032 starve_cnt (4 bits, internal): increment, saturating at STARVE_LIMIT, on each IDLE->DGRANT transition with iREN=1; clear on IGRANT completion or any cycle iREN=0.
REQ-033 Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_LIMIT: dcache wins.
REQ-034 An in-progress grant SHALL never be preempted by the other requester.

Reset
REQ-035 RST=1 at rising edge: state=IDLE, starve_cnt=0; next cycle owner=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-036 RST mid-grant SHALL abort the access; strobes low the cycle after RST sampled.

Verification
REQ-037 iREN=1 alone, iaddr=0x40, ramstate ACCESS on 3rd cycle of IGRANT -> ramREN=1 ramaddr=0x40 from cycle 2, iwait=0 once, iload=ramload, owner back to 0.
REQ-038 iREN and dWEN both asserted in IDLE, daddr=0x100 dstore=0xDEADBEEF -> DGRANT first, ramWEN=1 ramstore=0xDEADBEEF, iwait=1 throughout; IGRANT after dcache completion.
REQ-039 dREN held continuously with iREN=1, STARVE_LIMIT=8 -> exactly 8 dcache completions then one IGRANT, starve_cnt returns to 0.
REQ-040 dREN=dWEN=1 -> ramWEN=1, ramREN=0.
REQ-041 dREN dropped during DGRANT with ramstate BUSY -> strobes 0 same cycle, owner=0 next cycle, no dwait=0 pulse.
REQ-042 RST asserted during IGRANT with ramstate BUSY -> owner=0, all ram* 0 next cycle, starve_cnt=0.
